// File: rtl/clk_tick_pkg.sv
// Shared register offsets, bit positions and channel configuration type
// for the clock-enable generator bank.
package clk_tick_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DIV    = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_OVF_IE  = 2;

    localparam int STAT_PEND = 0;
    localparam int STAT_OVF  = 1;

    localparam int BUS_DW    = 32;
    localparam int DIV_W_MAX = 32;

    // div is stored at full bus width; each channel uses only its low DIV_W bits
    typedef struct packed {
        logic                 en;
        logic                 oneshot;
        logic                 ovf_ie;
        logic [DIV_W_MAX-1:0] div;
    } ch_cfg_t;

endpackage

// File: rtl/clk_tick_ctrl_if.sv
// Word-wide register bus between the core (master) and the tick bank (slave).
interface clk_tick_ctrl_if #(parameter int AW = 4);
    import clk_tick_pkg::*;

    // bus_wr/bus_rd are single-cycle strobes with no back-pressure; every read
    // is answered by exactly one bus_rvalid pulse on the following cycle.
    logic              bus_wr;
    logic              bus_rd;
    logic [AW-1:0]     bus_addr;
    logic [BUS_DW-1:0] bus_wdata;
    logic [BUS_DW-1:0] bus_rdata;
    logic              bus_rvalid;

    modport master (
        output bus_wr, bus_rd, bus_addr, bus_wdata,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_wr, bus_rd, bus_addr, bus_wdata,
        output bus_rdata, bus_rvalid
    );

endinterface

// File: rtl/clk_tick_channel.sv
// One tick channel: free-running divider, pending level and sticky overrun.
module clk_tick_channel
    import clk_tick_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  ch_cfg_t          cfg_q,
    input  ch_cfg_t          cfg_d,
    input  logic             cfg_wr,
    input  logic             ovf_clr,
    input  logic             ack,
    output logic             tick,
    output logic             pend,
    output logic             ovf,
    output logic             oneshot_clr,
    output logic [DIV_W-1:0] count
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] count_d;
    logic             tick_d;

    assign div_q = cfg_q.div[DIV_W-1:0];
    assign div_d = cfg_d.div[DIV_W-1:0];

    // A config write restarts the period; wrapping or disabled returns to 0.
    always_comb begin
        count_d = '0;
        if (cfg_q.en && !cfg_wr && (count != div_q)) begin
            count_d = count + DIV_W'(1);
        end
    end

    // tick is registered against the configuration that will be live next
    // cycle, so it lines up with count==DIV and DIV=0 ticks every cycle.
    assign tick_d      = cfg_d.en && (count_d == div_d);
    assign oneshot_clr = tick && cfg_q.oneshot;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
            pend  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_d;
            tick  <= tick_d;
            pend  <= tick | (pend & ~ack);
            ovf   <= (tick & pend & ~ack) | (ovf & ~ovf_clr);
        end
    end

endmodule

// File: rtl/clk_tick_ctrl.sv
// Bus-programmable bank of NUM_CH clock-enable generators with pending,
// overrun and a combined overrun interrupt.
module clk_tick_ctrl
    import clk_tick_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    clk_tick_ctrl_if.slave    bus,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] tick_pend,
    input  logic [NUM_CH-1:0] tick_ack,
    output logic              irq
);

    localparam logic [BUS_DW-1:0] DIV_MASK = BUS_DW'((64'd1 << DIV_W) - 64'd1);

    ch_cfg_t           cfg_q [NUM_CH];
    ch_cfg_t           cfg_d [NUM_CH];
    logic [DIV_W-1:0]  count [NUM_CH];
    logic [NUM_CH-1:0] cfg_wr;
    logic [NUM_CH-1:0] ovf_clr;
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] ovf_ie;
    logic [NUM_CH-1:0] oneshot_clr;
    logic [1:0]        reg_sel;
    int unsigned       ch_sel;
    logic [BUS_DW-1:0] rdata_d;

    assign reg_sel = bus.bus_addr[1:0];
    assign ch_sel  = 32'(bus.bus_addr >> 2);

    // Unmapped channel indices never match, so their writes fall away.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_d[i]   = cfg_q[i];
            cfg_wr[i]  = 1'b0;
            ovf_clr[i] = 1'b0;
            if (oneshot_clr[i]) cfg_d[i].en = 1'b0;
            if (bus.bus_wr && (ch_sel == i)) begin
                case (reg_sel)
                    REG_CTRL: begin
                        cfg_d[i].en      = bus.bus_wdata[CTRL_EN];
                        cfg_d[i].oneshot = bus.bus_wdata[CTRL_ONESHOT];
                        cfg_d[i].ovf_ie  = bus.bus_wdata[CTRL_OVF_IE];
                        cfg_wr[i]        = 1'b1;
                    end
                    REG_DIV: begin
                        cfg_d[i].div = bus.bus_wdata & DIV_MASK;
                        cfg_wr[i]    = 1'b1;
                    end
                    REG_STATUS: ovf_clr[i] = bus.bus_wdata[STAT_OVF];
                    default: ;
                endcase
            end
        end
    end

    // Read mux sees pre-edge state, so a same-cycle write returns old data.
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == i) begin
                case (reg_sel)
                    REG_CTRL: begin
                        rdata_d[CTRL_EN]      = cfg_q[i].en;
                        rdata_d[CTRL_ONESHOT] = cfg_q[i].oneshot;
                        rdata_d[CTRL_OVF_IE]  = cfg_q[i].ovf_ie;
                    end
                    REG_DIV: rdata_d = cfg_q[i].div;
                    REG_STATUS: begin
                        rdata_d[STAT_PEND] = tick_pend[i];
                        rdata_d[STAT_OVF]  = ovf[i];
                    end
                    default: rdata_d = BUS_DW'(count[i]);
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ovf_ie[g] = cfg_q[g].ovf_ie;

        clk_tick_channel #(.DIV_W(DIV_W)) u_ch (
            .clk         (clk),
            .reset       (reset),
            .cfg_q       (cfg_q[g]),
            .cfg_d       (cfg_d[g]),
            .cfg_wr      (cfg_wr[g]),
            .ovf_clr     (ovf_clr[g]),
            .ack         (tick_ack[g]),
            .tick        (tick[g]),
            .pend        (tick_pend[g]),
            .ovf         (ovf[g]),
            .oneshot_clr (oneshot_clr[g]),
            .count       (count[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) cfg_q[i] <= '0;
            bus.bus_rdata  <= '0;
            bus.bus_rvalid <= 1'b0;
            irq            <= 1'b0;
        end else begin
            cfg_q          <= cfg_d;
            bus.bus_rvalid <= bus.bus_rd;
            if (bus.bus_rd) bus.bus_rdata <= rdata_d;
            irq            <= |(ovf & ovf_ie);
        end
    end

endmodule

// File: tb/tb_clk_tick_ctrl.sv
// Directed bench for clk_tick_ctrl: divider latency, pending/overrun, irq,
// live reconfiguration, one-shot, unmapped channel and reset behaviour.
module tb_clk_tick_ctrl;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 16;
  localparam int AW     = 4;

  logic              clk;
  logic              reset;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] tick_pend;
  logic [NUM_CH-1:0] tick_ack;
  logic              irq;

  int n_checks;
  int n_errors;

  logic [31:0] exp_q[$];

  clk_tick_ctrl_if #(.AW(AW)) bus_if ();

  clk_tick_ctrl #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .tick      (tick),
    .tick_pend (tick_pend),
    .tick_ack  (tick_ack),
    .irq       (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr(input int ch, input int r);
    return AW'(ch * 4 + r);
  endfunction

  // Drivers: called at a negedge, return at the following negedge.
  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
    bus_if.bus_wr    = 1'b1;
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = d;
    @(negedge clk);
    bus_if.bus_wr    = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d, output logic v);
    bus_if.bus_rd   = 1'b1;
    bus_if.bus_addr = a;
    @(negedge clk);
    bus_if.bus_rd   = 1'b0;
    d = bus_if.bus_rdata;
    v = bus_if.bus_rvalid;
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    bus_read(a, d, v);
    check_eq({tag, "_rvalid"}, 32'(v), 32'd1);
    check_eq(tag, d, exp);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        v;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    tick_ack = '0;
    bus_if.bus_wr = 1'b0;
    bus_if.bus_rd = 1'b0;
    bus_if.bus_addr = '0;
    bus_if.bus_wdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_tick", 32'(tick), 32'd0);
    check_eq("rst_pend", 32'(tick_pend), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_rvalid", 32'(bus_if.bus_rvalid), 32'd0);
    check_eq("rst_rdata", bus_if.bus_rdata, 32'd0);
    reset = 1'b0;

    // 1: DIV=3, EN at cycle 0 -> ticks at 4, 8, 12; pend from 5
    bus_write(addr(0, 1), 32'd3);
    bus_write(addr(0, 0), 32'h1);
    for (int c = 1; c <= 13; c++) exp_q.push_back((c % 4 == 0) ? 32'd1 : 32'd0);
    for (int c = 1; c <= 13; c++) begin
      check_eq($sformatf("t1_tick_c%0d", c), 32'(tick[0]), exp_q.pop_front());
      check_eq($sformatf("t1_pend_c%0d", c), 32'(tick_pend[0]), (c >= 5) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    read_check("t1_status", addr(0, 2), 32'h3);

    // 2: DIV=0 with ack held -> tick every cycle, no overrun
    pulse_reset();
    tick_ack = 3'b010;
    bus_write(addr(1, 1), 32'd0);
    bus_write(addr(1, 0), 32'h1);
    for (int c = 1; c <= 6; c++) begin
      check_eq($sformatf("t2_tick_c%0d", c), 32'(tick[1]), 32'd1);
      @(negedge clk);
    end
    read_check("t2_status", addr(1, 2), 32'h1);
    tick_ack = '0;

    // 3: DIV=2, OVF_IE, no ack -> overrun and irq; then stop and clear
    pulse_reset();
    bus_write(addr(2, 1), 32'd2);
    bus_write(addr(2, 0), 32'h5);
    repeat (8) @(negedge clk);
    check_eq("t3_irq_set", 32'(irq), 32'd1);
    read_check("t3_status_ovf", addr(2, 2), 32'h3);
    bus_write(addr(2, 0), 32'h4);
    bus_write(addr(2, 2), 32'h2);
    @(negedge clk);
    check_eq("t3_irq_clr", 32'(irq), 32'd0);
    read_check("t3_status_clr", addr(2, 2), 32'h1);

    // 4: DIV=9, rewrite DIV=1 at count 5 -> restart, ticks every 2
    pulse_reset();
    bus_write(addr(2, 1), 32'd9);
    bus_write(addr(2, 0), 32'h1);
    repeat (3) @(negedge clk);
    read_check("t4_count3", addr(2, 3), 32'd3);
    @(negedge clk);
    bus_write(addr(2, 1), 32'd1);
    check_eq("t4_tick_c7", 32'(tick[2]), 32'd0);
    read_check("t4_count0", addr(2, 3), 32'd0);
    check_eq("t4_tick_c8", 32'(tick[2]), 32'd1);
    for (int c = 9; c <= 12; c++) begin
      @(negedge clk);
      check_eq($sformatf("t4_tick_c%0d", c), 32'(tick[2]), (c % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);

    // 5: ONESHOT, DIV=4 -> single tick at cycle 5, EN self-clears
    pulse_reset();
    bus_write(addr(0, 1), 32'd4);
    bus_write(addr(0, 0), 32'h3);
    for (int c = 1; c <= 14; c++) begin
      check_eq($sformatf("t5_tick_c%0d", c), 32'(tick[0]), (c == 5) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    read_check("t5_count", addr(0, 3), 32'd0);
    read_check("t5_ctrl", addr(0, 0), 32'h2);
    bus_write(addr(3, 0), 32'h1);
    read_check("t5_bad_ch", addr(3, 0), 32'd0);
    check_eq("t5_bad_ch_tick", 32'(tick), 32'd0);

    // 6: reset mid-count with all channels active
    pulse_reset();
    bus_write(addr(0, 1), 32'd1);
    bus_write(addr(0, 0), 32'h1);
    bus_write(addr(1, 0), 32'h1);
    bus_write(addr(2, 1), 32'd2);
    bus_write(addr(2, 0), 32'h5);
    repeat (10) @(negedge clk);
    check_eq("t6_pre_irq", 32'(irq), 32'd1);
    check_eq("t6_pre_pend", 32'(tick_pend), 32'h7);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t6_tick", 32'(tick), 32'd0);
    check_eq("t6_pend", 32'(tick_pend), 32'd0);
    check_eq("t6_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int r = 0; r < 4; r++) begin
        read_check($sformatf("t6_reg_%0d_%0d", ch, r), addr(ch, r), 32'd0);
      end
    end

    // read and write together: old value back, DIV upper bits dropped
    bus_if.bus_rd = 1'b1;
    bus_write(addr(1, 1), 32'hFFFF_5A5A);
    bus_if.bus_rd = 1'b0;
    d = bus_if.bus_rdata;
    v = bus_if.bus_rvalid;
    check_eq("rw_rvalid", 32'(v), 32'd1);
    check_eq("rw_old", d, 32'd0);
    read_check("div_trunc", addr(1, 1), 32'h0000_5A5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
